// File: rtl/jt51_lfo_pm.sv
// LFO phase-modulation source: per-frame phase step, waveform select, serial depth multiply.
// pm/pm_upd update 9 cen cycles after zero; no backpressure, the strobe is not held.
module jt51_lfo_pm #(
   parameter logic [16:0] LFSR_SEED = 17'h1,
   parameter int          ACC_W     = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       zero,
   input  logic       lfo_rst,
   input  logic [7:0] lfo_freq,
   input  logic [1:0] lfo_w,
   input  logic [6:0] lfo_pmd,
   output logic [7:0] pm,
   output logic       pm_upd
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] MUL  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [ACC_W-1:0] acc, step, acc_nxt;
   logic [16:0]      lfsr;
   logic [1:0]       st;
   logic [2:0]       cnt;
   logic             sgn;
   logic [6:0]       dsh;
   logic [13:0]      ash, prod;
   logic [7:0]       p, s, s_abs;
   logic [6:0]       tv, a_nxt, mag;

   always_comb begin
      step = '0;
      if (lfo_freq != 8'd0)
         step = ACC_W'({1'b1, lfo_freq[3:0]}) << lfo_freq[7:4];
   end

   assign acc_nxt = acc + step;
   assign p       = acc[ACC_W-1 -: 8];
   assign tv      = {p[5:0], 1'b0};
   assign mag     = prod[13:7];

   // Signed waveform sample, then magnitude clipped to 7 bits (-128 saturates to 127)
   always_comb begin
      s = 8'd0;
      case (lfo_w)
         2'd0: s = p ^ 8'h80;
         2'd1: s = p[7] ? 8'h80 : 8'h7F;
         2'd2: begin
            case (p[7:6])
               2'd0:    s = {1'b0, tv};
               2'd1:    s = {1'b0, 7'd127 - tv};
               2'd2:    s = 8'd0 - {1'b0, tv};
               default: s = 8'd0 - {1'b0, 7'd127 - tv};
            endcase
         end
         default: s = lfsr[7:0];
      endcase
      s_abs = s[7] ? 8'd0 - s : s;
      a_nxt = s_abs[7] ? 7'h7F : s_abs[6:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         lfsr   <= LFSR_SEED;
         st     <= IDLE;
         cnt    <= 3'd0;
         sgn    <= 1'b0;
         dsh    <= 7'd0;
         ash    <= 14'd0;
         prod   <= 14'd0;
         pm     <= 8'd0;
         pm_upd <= 1'b0;
      end else if (cen) begin
         if (lfo_rst) begin
            acc    <= '0;
            lfsr   <= LFSR_SEED;
            st     <= IDLE;
            cnt    <= 3'd0;
            sgn    <= 1'b0;
            dsh    <= 7'd0;
            ash    <= 14'd0;
            prod   <= 14'd0;
            pm     <= 8'd0;
            pm_upd <= 1'b0;
         end else begin
            pm_upd <= 1'b0;
            if (zero) begin
               // A zero in any state restarts the computation from LOAD
               acc <= acc_nxt;
               if (acc_nxt[ACC_W-1 -: 4] != acc[ACC_W-1 -: 4])
                  lfsr <= {lfsr[15:0], lfsr[16] ^ lfsr[13]};
               st <= LOAD;
            end else begin
               case (st)
                  LOAD: begin
                     sgn  <= s[7];
                     ash  <= {7'd0, a_nxt};
                     dsh  <= lfo_pmd;
                     prod <= 14'd0;
                     cnt  <= 3'd0;
                     st   <= MUL;
                  end
                  MUL: begin
                     if (dsh[0])
                        prod <= prod + ash;
                     ash <= ash << 1;
                     dsh <= dsh >> 1;
                     cnt <= cnt + 3'd1;
                     if (cnt == 3'd6)
                        st <= DONE;
                  end
                  DONE: begin
                     pm     <= {sgn & (mag != 7'd0), mag};
                     pm_upd <= 1'b1;
                     st     <= IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_jt51_lfo_pm.sv
// Randomized and directed bench for jt51_lfo_pm against a frame-level reference model.
module tb_jt51_lfo_pm;

   logic       clk = 1'b0;
   logic       rst, cen, zero, lfo_rst;
   logic [7:0] lfo_freq;
   logic [1:0] lfo_w;
   logic [6:0] lfo_pmd;
   logic [7:0] pm;
   logic       pm_upd;

   always #5 clk = ~clk;

   jt51_lfo_pm dut (
      .clk(clk), .rst(rst), .cen(cen), .zero(zero), .lfo_rst(lfo_rst),
      .lfo_freq(lfo_freq), .lfo_w(lfo_w), .lfo_pmd(lfo_pmd),
      .pm(pm), .pm_upd(pm_upd)
   );

   int n_chk, n_err;
   int m_acc, m_lfsr, m_pm, m_upd, m_t, m_pend;
   int gap_mode;
   int upd_slot, last_zero;
   bit rnd_in;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected pm from phase, waveform, depth and noise register, in plain integer arithmetic
   function automatic int ref_pm(input int p, input int w, input int pmd, input int lf);
      int s, mag, m;
      case (w)
         0: s = p - 128;
         1: s = (p >= 128) ? -128 : 127;
         2: begin
            m = p % 64;
            case (p / 64)
               0:       s = 2 * m;
               1:       s = 127 - 2 * m;
               2:       s = -2 * m;
               default: s = -(127 - 2 * m);
            endcase
         end
         default: begin
            s = lf & 255;
            if (s >= 128) s = s - 256;
         end
      endcase
      mag = (s < 0) ? -s : s;
      if (mag > 127) mag = 127;
      mag = (mag * pmd) / 128;
      if (mag == 0) return 0;
      return (s < 0) ? 128 + mag : mag;
   endfunction

   task automatic m_step(input bit z, input bit r);
      int stp, nacc, fb;
      if (r) begin
         m_acc = 0; m_lfsr = 1; m_pm = 0; m_upd = 0; m_t = -1;
      end else begin
         m_upd = 0;
         if (z) begin
            stp  = (lfo_freq == 8'd0) ? 0 : ((16 + int'(lfo_freq[3:0])) << lfo_freq[7:4]);
            nacc = (m_acc + stp) % (1 << 20);
            if ((nacc >> 16) != (m_acc >> 16)) begin
               fb     = ((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1;
               m_lfsr = ((m_lfsr << 1) | fb) & 'h1FFFF;
            end
            m_acc = nacc;
            m_t   = 0;
         end else if (m_t >= 0) begin
            m_t++;
            if (m_t == 1)
               m_pend = ref_pm((m_acc >> 12) & 255, int'(lfo_w), int'(lfo_pmd), m_lfsr);
            if (m_t == 9) begin
               m_pm = m_pend; m_upd = 1; m_t = -1;
            end
         end
      end
   endtask

   // One cen=1 cycle, optionally preceded by cen=0 cycles carrying junk on zero/lfo_rst
   task automatic cyc(input bit z, input bit r, input int slot);
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
         @(negedge clk);
         cen = 1'b0; zero = 1'($urandom); lfo_rst = 1'($urandom);
         @(posedge clk); #1;
         chk("frz_pm", int'(pm), m_pm);
         chk("frz_upd", int'(pm_upd), m_upd);
      end
      @(negedge clk);
      cen = 1'b1; zero = z; lfo_rst = r;
      if (rnd_in) begin
         lfo_freq = 8'($urandom); lfo_w = 2'($urandom); lfo_pmd = 7'($urandom);
      end
      @(posedge clk);
      m_step(z, r);
      #1;
      chk("pm", int'(pm), m_pm);
      chk("upd", int'(pm_upd), m_upd);
      if (z) last_zero = slot;
      if (pm_upd) upd_slot = slot;
   endtask

   task automatic run_frame(input int late_z, input int rst_at);
      upd_slot  = -1;
      last_zero = 0;
      for (int i = 0; i < 32; i++)
         cyc((i == 0) || (i == late_z), i == rst_at, i);
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b1; cen = 1'b0; zero = 1'b0; lfo_rst = 1'b0;
      lfo_freq = 8'h00; lfo_w = 2'd0; lfo_pmd = 7'd127;
      gap_mode = 0; rnd_in = 1'b0;
      m_acc = 0; m_lfsr = 1; m_pm = 0; m_upd = 0; m_t = -1; m_pend = 0;
      upd_slot = -1; last_zero = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pm", int'(pm), 0);
      chk("rst_upd", int'(pm_upd), 0);
      @(negedge clk);
      rst = 1'b0;

      repeat (3) run_frame(-1, -1);
      chk("frozen_pm", int'(pm), 'hFE);
      chk("frozen_lat", upd_slot, 9);

      lfo_pmd  = 7'd0;
      lfo_freq = 8'h93;
      for (int w = 0; w < 4; w++) begin
         lfo_w = 2'(w);
         run_frame(-1, -1);
         chk("zdepth_pm", int'(pm), 0);
      end

      cyc(1'b0, 1'b1, 0);
      lfo_freq = 8'h80; lfo_w = 2'd1; lfo_pmd = 7'd64;
      for (int f = 1; f <= 256; f++) begin
         run_frame(-1, -1);
         if (f == 1 || f == 127) chk("sq_pos", int'(pm), 'h3F);
         if (f == 128 || f == 255) chk("sq_neg", int'(pm), 'hBF);
         if (f == 256) chk("sq_wrap", int'(pm), 'h3F);
      end

      cyc(1'b0, 1'b1, 0);
      lfo_w = 2'd2; lfo_pmd = 7'd127;
      for (int f = 1; f <= 160; f++) begin
         run_frame(-1, -1);
         if (f == 32) chk("tri_32", int'(pm), 'h3F);
         if (f == 64) chk("tri_64", int'(pm), 'h7E);
         if (f == 160) chk("tri_160", int'(pm), 'hBF);
      end

      lfo_w = 2'd1; lfo_pmd = 7'd64;
      run_frame(-1, -1);
      run_frame(-1, 4);
      chk("midrst_upd", upd_slot, -1);
      chk("midrst_pm", int'(pm), 0);
      run_frame(-1, -1);
      chk("resume_pm", int'(pm), 'h3F);

      gap_mode = 1;
      run_frame(5, -1);
      chk("late_zero_lat", upd_slot - last_zero, 9);
      chk("late_zero_pm", int'(pm), 'h3F);

      gap_mode = 2;
      rnd_in   = 1'b1;
      for (int f = 0; f < 150; f++)
         run_frame(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : -1,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 31)) : -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
